mm_sequencer: RTL and testbench
===============================

MM_SEQUENCER -- requirements
Module: mm_sequencer

Interface
REQ-001 Parameters SHALL be: DIM_LOG, default 1, log2 of matrix dimension; DATA_WIDTH, default 32, element width; DIM=2**DIM_LOG, SIZE=DIM*DIM, SIZE_LOG=2*DIM_LOG (derived, not overridden).
REQ-002 Ports SHALL be, clock and reset first:
- s00_axi_aclk  in  1  sole clock, rising edge.
- s00_axi_aresetn  in  1  asynchronous active-low reset.
- start  in  1  run request from AXI-Lite slave.
- s00_axis_tvalid, s00_axis_tlast  in  1 each  input stream qualifiers.
- s00_axis_tready  out  1  input stream ready.
- m00_axis_tready  in  1  output stream ready.
- m00_axis_tvalid, m00_axis_tlast  out  1 each  output stream qualifiers.
- en_A, we_A, en_B, we_B, en_R, we_R  out  1 each  BRAM enable/write strobes.
- addr_A, addr_B, addr_R  out  SIZE_LOG each  BRAM addresses.
- mac_clear  out  1  MAC loads product instead of accumulating.
- mac_en  out  1  MAC operand valid this cycle.
- busy, done, err_tlast  out  1 each  status.

Function
REQ-003 FSM states SHALL be S_IDLE, S_LOAD_A, S_LOAD_B, S_CALC, S_DRAIN, S_OUT_RD, S_OUT_WR.
REQ-004 S_IDLE: start=1 SHALL go to S_LOAD_A, zero all counters, clear err_tlast; start outside S_IDLE SHALL be ignored.
REQ-005 S_LOAD_A/S_LOAD_B SHALL drive s00_axis_tready=1; each beat with tvalid&tready SHALL assert en_X=we_X=1 with addr_X=load count, row-major; load count SHALL increment per beat only.
REQ-006 The beat with load count SIZE-1 SHALL transition S_LOAD_A->S_LOAD_B or S_LOAD_B->S_CALC and wrap the count to 0.
REQ-007 err_tlast SHALL set (sticky) when s00_axis_tlast on an accepted beat differs from (count==SIZE-1); beat counting SHALL be unaffected.
REQ-008 S_CALC SHALL issue one read per cycle over nested counters i (outer), j, k (inner), each DIM_LOG bits: en_A=en_B=1, addr_A=i*DIM+k, addr_B=k*DIM+j, we_A=we_B=0.
REQ-009 BRAM read latency is one cycle; mac_en SHALL be the issue strobe delayed 1 cycle, mac_clear the (k==0) flag delayed 1 cycle.
REQ-010 MAC output is registered; en_R=we_R=1 with addr_R=i*DIM+j SHALL occur 2 cycles after issue of k=DIM-1 for that (i,j).
REQ-011 After issuing i=j=k=DIM-1 the FSM SHALL enter S_DRAIN for exactly 2 cycles (last R write completes), then S_OUT_RD with addr_R=0.
REQ-012 S_CALC total SHALL be SIZE*DIM cycles; start-to-first-output latency after loads = SIZE*DIM+3 cycles.
REQ-013 S_OUT_RD SHALL assert en_R=1, we_R=0 for one cycle, then go to S_OUT_WR.
REQ-014 S_OUT_WR SHALL hold m00_axis_tvalid=1, en_R=0 (BRAM output held) until m00_axis_tready=1; m00_axis_tlast=1 only when addr_R=SIZE-1.
REQ-015 On handshake: if addr_R<SIZE-1, increment addr_R and go to S_OUT_RD; else go to S_IDLE and pulse done for one cycle.
REQ-016 m00_axis_tvalid SHALL never drop before handshake; m00_axis_tdata is outside this block (BRAM R data_out).
REQ-017 busy SHALL be 1 in every state except S_IDLE.
REQ-018 All write strobes SHALL be mutually exclusive per BRAM per cycle; we_X=1 implies en_X=1.

Reset
REQ-019 Reset assertion SHALL asynchronously force S_IDLE and all outputs, counters, delay pipes to 0, including mid-load, mid-calc, mid-output.
REQ-020 After reset deassertion the block SHALL require a new start; partial BRAM contents are not cleared.

Structure
REQ-021 Package mm_pkg SHALL hold the state enumeration, default DIM_LOG/DATA_WIDTH and SIZE/SIZE_LOG derivation functions.
REQ-022 The i/j/k counter and address computation SHALL be sub-module mm_calc_agen (inputs step, clear; outputs addr_A, addr_B, addr_R, first_k, last_k, last_all).

Verification (DIM_LOG=1, behavioural BRAMs and MAC attached)
REQ-023 start; A=1,2,3,4; B=5,6,7,8, tlast on beat 4 of each -> output 19,22,43,50, tlast on 50, done pulse, err_tlast=0.
REQ-024 Same data with tvalid low every other cycle and m00_axis_tready low 3 cycles per beat -> identical output, no dropped or duplicated beat, tvalid stable while stalled.
REQ-025 tlast on beat 2 of A -> err_tlast=1, loading continues to 4+4 beats, result still 19,22,43,50.
REQ-026 start pulsed during S_CALC -> ignored; one output matrix only.
REQ-027 Reset asserted mid-S_CALC -> all outputs 0 same cycle; new start with A=identity, B=5,6,7,8 -> 5,6,7,8.
REQ-028 Count S_CALC+S_DRAIN cycles = 10 and first m00_axis_tvalid exactly 1 cycle after S_DRAIN exits.

Source files
------------

// File: rtl/mm_pkg.sv
// Shared types and size helpers for the matrix-multiply sequencer.
package mm_pkg;

    localparam int DEF_DIM_LOG    = 1;
    localparam int DEF_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_CALC   = 3'd3,
        S_DRAIN  = 3'd4,
        S_OUT_RD = 3'd5,
        S_OUT_WR = 3'd6
    } state_t;

    // Number of elements in a DIM x DIM matrix.
    function automatic int mm_size(input int dim_log);
        return 1 << (2 * dim_log);
    endfunction

    // Address width of one matrix BRAM.
    function automatic int mm_size_log(input int dim_log);
        return 2 * dim_log;
    endfunction

endpackage

// File: rtl/mm_sequencer_if.sv
// Stream handshake bundle between the sequencer and its AXI-Stream neighbours.
interface mm_sequencer_if;
    logic s00_axis_tvalid;
    logic s00_axis_tlast;
    logic s00_axis_tready;
    logic m00_axis_tvalid;
    logic m00_axis_tlast;
    logic m00_axis_tready;

    // Environment side: feeds the input stream, consumes the output stream.
    modport master (
        output s00_axis_tvalid, s00_axis_tlast, m00_axis_tready,
        input  s00_axis_tready, m00_axis_tvalid, m00_axis_tlast
    );

    // Sequencer side.
    modport slave (
        input  s00_axis_tvalid, s00_axis_tlast, m00_axis_tready,
        output s00_axis_tready, m00_axis_tvalid, m00_axis_tlast
    );
endinterface

// File: rtl/mm_calc_agen.sv
// Nested i/j/k counters for the multiply phase and the A/B/R addresses they imply.
module mm_calc_agen
    import mm_pkg::*;
#(
    parameter  int DIM_LOG  = DEF_DIM_LOG,
    localparam int SIZE_LOG = mm_size_log(DIM_LOG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                step,
    input  logic                clear,
    output logic [SIZE_LOG-1:0] addr_A,
    output logic [SIZE_LOG-1:0] addr_B,
    output logic [SIZE_LOG-1:0] addr_R,
    output logic                first_k,
    output logic                last_k,
    output logic                last_all
);

    logic [DIM_LOG-1:0] i, j, k;

    // k is innermost; counters wrap to zero naturally after the last (i,j,k).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i <= '0;
            j <= '0;
            k <= '0;
        end else if (clear) begin
            i <= '0;
            j <= '0;
            k <= '0;
        end else if (step) begin
            k <= k + 1'b1;
            if (&k) begin
                j <= j + 1'b1;
                if (&j) i <= i + 1'b1;
            end
        end
    end

    // Row-major: A[i][k], B[k][j], R[i][j].
    assign addr_A   = {i, k};
    assign addr_B   = {k, j};
    assign addr_R   = {i, j};
    assign first_k  = (k == '0);
    assign last_k   = &k;
    assign last_all = &{i, j, k};

endmodule

// File: rtl/mm_sequencer.sv
// Control sequencer for a BRAM-based matrix multiplier: loads A and B from a
// stream, walks the i/j/k product schedule, then streams R back out.
module mm_sequencer
    import mm_pkg::*;
#(
    parameter  int DIM_LOG    = DEF_DIM_LOG,
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    localparam int DIM        = 2 ** DIM_LOG,
    localparam int SIZE       = DIM * DIM,
    localparam int SIZE_LOG   = mm_size_log(DIM_LOG)
) (
    input  logic                s00_axi_aclk,
    input  logic                s00_axi_aresetn,
    input  logic                start,
    mm_sequencer_if.slave       axis,
    output logic                en_A,
    output logic                we_A,
    output logic                en_B,
    output logic                we_B,
    output logic                en_R,
    output logic                we_R,
    output logic [SIZE_LOG-1:0] addr_A,
    output logic [SIZE_LOG-1:0] addr_B,
    output logic [SIZE_LOG-1:0] addr_R,
    output logic                mac_clear,
    output logic                mac_en,
    output logic                busy,
    output logic                done,
    output logic                err_tlast
);

    // Element width only sizes the external BRAM/MAC datapath.
    if (DATA_WIDTH < 1) begin : g_bad_width
        $error("mm_sequencer: DATA_WIDTH must be positive");
    end

    localparam logic [SIZE_LOG-1:0] LAST_IDX = SIZE_LOG'(SIZE - 1);

    state_t              state;
    logic [SIZE_LOG-1:0] load_cnt;
    logic [SIZE_LOG-1:0] out_addr;
    logic                drain_cnt;
    logic                beat;
    logic                last_beat;
    logic                issue;

    logic [SIZE_LOG-1:0] ag_addr_a, ag_addr_b, ag_addr_r;
    logic                first_k, last_k, last_all;

    // R write pipe: stage 0 = BRAM read in flight, stage 1 = MAC result ready.
    logic [1:0]          rwr_pipe;
    logic [SIZE_LOG-1:0] raddr_pipe [2];

    assign axis.s00_axis_tready = (state == S_LOAD_A) || (state == S_LOAD_B);
    assign beat      = axis.s00_axis_tvalid && axis.s00_axis_tready;
    assign last_beat = (load_cnt == LAST_IDX);
    assign issue     = (state == S_CALC);

    mm_calc_agen #(.DIM_LOG(DIM_LOG)) u_agen (
        .clk      (s00_axi_aclk),
        .rst_n    (s00_axi_aresetn),
        .step     (issue),
        .clear    ((state == S_IDLE) && start),
        .addr_A   (ag_addr_a),
        .addr_B   (ag_addr_b),
        .addr_R   (ag_addr_r),
        .first_k  (first_k),
        .last_k   (last_k),
        .last_all (last_all)
    );

    // Main FSM: phase sequencing, load/output counters, status flags.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state     <= S_IDLE;
            load_cnt  <= '0;
            out_addr  <= '0;
            drain_cnt <= 1'b0;
            done      <= 1'b0;
            err_tlast <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_LOAD_A;
                        load_cnt  <= '0;
                        out_addr  <= '0;
                        drain_cnt <= 1'b0;
                        err_tlast <= 1'b0;
                    end
                end
                S_LOAD_A, S_LOAD_B: begin
                    if (beat) begin
                        load_cnt <= load_cnt + SIZE_LOG'(1);
                        // Misplaced tlast is only flagged; the beat count rules.
                        if (axis.s00_axis_tlast != last_beat) err_tlast <= 1'b1;
                        if (last_beat) state <= (state == S_LOAD_A) ? S_LOAD_B : S_CALC;
                    end
                end
                S_CALC: begin
                    if (last_all) begin
                        state     <= S_DRAIN;
                        drain_cnt <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    // Two cycles lets the last MAC result land in R.
                    if (drain_cnt) begin
                        state    <= S_OUT_RD;
                        out_addr <= '0;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                S_OUT_RD: state <= S_OUT_WR;
                S_OUT_WR: begin
                    if (axis.m00_axis_tready) begin
                        if (out_addr == LAST_IDX) begin
                            state <= S_IDLE;
                            done  <= 1'b1;
                        end else begin
                            out_addr <= out_addr + SIZE_LOG'(1);
                            state    <= S_OUT_RD;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Align MAC strobes and R writes with the one-cycle BRAM read and registered MAC.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            mac_en        <= 1'b0;
            mac_clear     <= 1'b0;
            rwr_pipe      <= '0;
            raddr_pipe[0] <= '0;
            raddr_pipe[1] <= '0;
        end else begin
            mac_en        <= issue;
            mac_clear     <= issue && first_k;
            rwr_pipe      <= {rwr_pipe[0], issue && last_k};
            raddr_pipe[0] <= ag_addr_r;
            raddr_pipe[1] <= raddr_pipe[0];
        end
    end

    // BRAM port steering per phase; the R write pipe only fires in CALC/DRAIN.
    always_comb begin
        en_A   = 1'b0;
        we_A   = 1'b0;
        addr_A = '0;
        en_B   = 1'b0;
        we_B   = 1'b0;
        addr_B = '0;
        en_R   = 1'b0;
        we_R   = 1'b0;
        addr_R = '0;
        case (state)
            S_LOAD_A: begin
                en_A   = beat;
                we_A   = beat;
                addr_A = load_cnt;
            end
            S_LOAD_B: begin
                en_B   = beat;
                we_B   = beat;
                addr_B = load_cnt;
            end
            S_CALC: begin
                en_A   = 1'b1;
                en_B   = 1'b1;
                addr_A = ag_addr_a;
                addr_B = ag_addr_b;
            end
            S_OUT_RD: begin
                en_R   = 1'b1;
                addr_R = out_addr;
            end
            S_OUT_WR: addr_R = out_addr;
            default: ;
        endcase
        if (rwr_pipe[1]) begin
            en_R   = 1'b1;
            we_R   = 1'b1;
            addr_R = raddr_pipe[1];
        end
    end

    assign axis.m00_axis_tvalid = (state == S_OUT_WR);
    assign axis.m00_axis_tlast  = (state == S_OUT_WR) && (out_addr == LAST_IDX);
    assign busy                 = (state != S_IDLE);

endmodule

// File: tb/tb_mm_sequencer.sv
// Directed bench for mm_sequencer with behavioural A/B/R BRAMs and a MAC.
module tb_mm_sequencer;
    import mm_pkg::*;

    localparam int DIM_LOG = 1;
    localparam int DW      = 32;
    localparam int SIZE    = 4;
    localparam int SL      = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic          en_A, we_A, en_B, we_B, en_R, we_R;
    logic [SL-1:0] addr_A, addr_B, addr_R;
    logic          mac_clear, mac_en, busy, done, err_tlast;

    int vectors = 0;
    int miscompares = 0;

    mm_sequencer_if sif();

    mm_sequencer #(.DIM_LOG(DIM_LOG), .DATA_WIDTH(DW)) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .start           (start),
        .axis            (sif),
        .en_A            (en_A),
        .we_A            (we_A),
        .en_B            (en_B),
        .we_B            (we_B),
        .en_R            (en_R),
        .we_R            (we_R),
        .addr_A          (addr_A),
        .addr_B          (addr_B),
        .addr_R          (addr_R),
        .mac_clear       (mac_clear),
        .mac_en          (mac_en),
        .busy            (busy),
        .done            (done),
        .err_tlast       (err_tlast)
    );

    always #5 clk = ~clk;

    // Behavioural BRAMs (1-cycle read) and registered MAC.
    logic [DW-1:0] mem_a [SIZE];
    logic [DW-1:0] mem_b [SIZE];
    logic [DW-1:0] mem_r [SIZE];
    logic [DW-1:0] dout_a = '0, dout_b = '0, dout_r = '0, acc = '0;

    always @(posedge clk) begin
        if (en_A) begin
            if (we_A) mem_a[addr_A] <= s_tdata;
            else      dout_a <= mem_a[addr_A];
        end
        if (en_B) begin
            if (we_B) mem_b[addr_B] <= s_tdata;
            else      dout_b <= mem_b[addr_B];
        end
        if (en_R) begin
            if (we_R) mem_r[addr_R] <= acc;
            else      dout_r <= mem_r[addr_R];
        end
        if (mac_en) acc <= mac_clear ? dout_a * dout_b : acc + dout_a * dout_b;
    end

    logic [DW-1:0] mat_a  [4] = '{32'd1, 32'd2, 32'd3, 32'd4};
    logic [DW-1:0] mat_b  [4] = '{32'd5, 32'd6, 32'd7, 32'd8};
    logic [DW-1:0] mat_id [4] = '{32'd1, 32'd0, 32'd0, 32'd1};
    logic [DW-1:0] res_ab [4] = '{32'd19, 32'd22, 32'd43, 32'd50};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push(input logic [DW-1:0] d, input logic last, input int gap,
                        input int idx, input bit is_a);
        int n;
        for (int g = 0; g < gap; g++) begin
            sif.s00_axis_tvalid = 1'b0;
            tick();
        end
        sif.s00_axis_tvalid = 1'b1;
        sif.s00_axis_tlast  = last;
        s_tdata             = d;
        #1;
        n = 0;
        while (!sif.s00_axis_tready && n < 20) begin
            tick();
            n++;
        end
        chk("in_tready", 32'(sif.s00_axis_tready), 32'd1);
        if (is_a) begin
            chk("ld_en_we_A", 32'({en_A, we_A}), 32'd3);
            chk("ld_addr_A", 32'(addr_A), 32'(idx));
        end else begin
            chk("ld_en_we_B", 32'({en_B, we_B}), 32'd3);
            chk("ld_addr_B", 32'(addr_B), 32'(idx));
        end
        tick();
        sif.s00_axis_tvalid = 1'b0;
        sif.s00_axis_tlast  = 1'b0;
    endtask

    task automatic load(input logic [DW-1:0] a [4], input logic [DW-1:0] b [4],
                        input int gap, input int bad);
        for (int n = 0; n < 4; n++) push(a[n], (n == 3) || (n == bad), gap, n, 1'b1);
        chk("err_after_A", 32'(err_tlast), (bad >= 0) ? 32'd1 : 32'd0);
        for (int n = 0; n < 4; n++) push(b[n], n == 3, gap, n, 1'b0);
    endtask

    task automatic get_out(input logic [DW-1:0] exp, input bit exp_last, input int stall);
        int n;
        logic [DW-1:0] hold;
        n = 0;
        while (!sif.m00_axis_tvalid && n < 40) begin
            tick();
            n++;
        end
        chk("out_tvalid", 32'(sif.m00_axis_tvalid), 32'd1);
        hold = dout_r;
        for (int s = 0; s < stall; s++) begin
            tick();
            chk("stall_tvalid", 32'(sif.m00_axis_tvalid), 32'd1);
            chk("stall_tdata", dout_r, hold);
        end
        sif.m00_axis_tready = 1'b1;
        #1;
        chk("out_tdata", dout_r, exp);
        chk("out_tlast", 32'(sif.m00_axis_tlast), 32'(exp_last));
        tick();
        sif.m00_axis_tready = 1'b0;
    endtask

    task automatic get_matrix(input logic [DW-1:0] r [4], input int stall);
        for (int n = 0; n < 4; n++) get_out(r[n], n == 3, stall);
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("no_extra_beat", 32'(sif.m00_axis_tvalid), 32'd0);
        tick();
        chk("done_drop", 32'(done), 32'd0);
    endtask

    initial begin
        int calc, drain, rw;
        sif.s00_axis_tvalid = 1'b0;
        sif.s00_axis_tlast  = 1'b0;
        sif.m00_axis_tready = 1'b0;

        // Reset state
        #22;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done_err", 32'({done, err_tlast}), 32'd0);
        chk("rst_strobes", 32'({en_A, we_A, en_B, we_B, en_R, we_R, mac_en, mac_clear}), 32'd0);
        chk("rst_stream", 32'({sif.s00_axis_tready, sif.m00_axis_tvalid, sif.m00_axis_tlast}), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);

        // Basic run with calc schedule and timing checks
        pulse_start();
        chk("start_busy", 32'(busy), 32'd1);
        load(mat_a, mat_b, 0, -1);
        calc = 0;
        rw = 0;
        while (en_A && !we_A && calc < 20) begin
            chk("calc_addr_A", 32'(addr_A), 32'(((calc >> 2) & 1) * 2 + (calc & 1)));
            chk("calc_addr_B", 32'(addr_B), 32'((calc & 1) * 2 + ((calc >> 1) & 1)));
            chk("calc_mac_en", 32'(mac_en), 32'(calc >= 1));
            chk("calc_mac_clear", 32'(mac_clear), 32'(calc >= 1 && ((calc - 1) & 1) == 0));
            if (en_R && we_R) begin
                chk("r_wr_addr", 32'(addr_R), 32'(rw));
                rw++;
            end
            tick();
            calc++;
        end
        drain = 0;
        while (!(en_R && !we_R) && drain < 10) begin
            if (en_R && we_R) begin
                chk("r_wr_addr", 32'(addr_R), 32'(rw));
                rw++;
            end
            tick();
            drain++;
        end
        chk("calc_cycles", 32'(calc), 32'd8);
        chk("drain_cycles", 32'(drain), 32'd2);
        chk("calc_plus_drain", 32'(calc + drain), 32'd10);
        chk("r_writes", 32'(rw), 32'd4);
        chk("out_rd_addr", 32'(addr_R), 32'd0);
        chk("out_rd_tvalid", 32'(sif.m00_axis_tvalid), 32'd0);
        tick();
        chk("first_tvalid", 32'(sif.m00_axis_tvalid), 32'd1);
        get_matrix(res_ab, 0);
        chk("err_clean", 32'(err_tlast), 32'd0);

        // Input bubbles and output backpressure
        pulse_start();
        load(mat_a, mat_b, 1, -1);
        get_matrix(res_ab, 3);
        chk("err_clean2", 32'(err_tlast), 32'd0);

        // Early tlast on beat 2 of A
        pulse_start();
        load(mat_a, mat_b, 0, 1);
        get_matrix(res_ab, 0);
        chk("err_sticky", 32'(err_tlast), 32'd1);

        // Start pulsed during CALC is ignored
        pulse_start();
        chk("err_cleared", 32'(err_tlast), 32'd0);
        load(mat_a, mat_b, 0, -1);
        tick();
        pulse_start();
        get_matrix(res_ab, 0);
        for (int n = 0; n < 4; n++) begin
            chk("no_rerun", 32'({busy, sif.m00_axis_tvalid}), 32'd0);
            tick();
        end

        // Reset mid-CALC, then identity run
        pulse_start();
        load(mat_a, mat_b, 0, -1);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_strobes", 32'({en_A, we_A, en_B, we_B, en_R, we_R, mac_en, mac_clear}), 32'd0);
        chk("midrst_addr", 32'({addr_A, addr_B, addr_R}), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_idle", 32'(busy), 32'd0);
        pulse_start();
        load(mat_id, mat_b, 0, -1);
        get_matrix(mat_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
